z80_irq_responder: RTL and testbench

//  Interrupt-side responder for the tv80 core: collects peripheral requests, drives cpu_int_n/cpu_nmi_n,

---
 rtl/z80_irq_responder.sv | 200 ++++++++++++++++++++
 tb/tb_z80_irq_responder.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/z80_irq_responder.sv
// z80_irq_responder: interrupt-side responder for the tv80 core.
//   Latches edge-triggered peripheral requests, drives cpu_int_n / cpu_nmi_n, answers the
//   INT-acknowledge cycle (M1+IORQ) with an IM2 vector or an RST opcode, and tracks the source
//   in service until RETI (ED 4D) is fetched or eoi is pulsed.
// Ports:
//   clk, reset            rising-edge clock, synchronous active-high reset
//   irq_req, irq_mask     per-source request (edge) and mask (1 = not signalled)
//   nmi_req               rising edge -> one NMI_HOLD-clock pulse on cpu_nmi_n
//   eoi                   end of interrupt, clears in-service from SERVICE/SEEN_ED
//   im_mode               CPU interrupt mode (>=2 selects vector output)
//   cpu_m1_n .. cpu_do    tv80 bus monitor inputs
//   cpu_int_n, cpu_nmi_n  registered active-low interrupt lines to the CPU
//   vec_out, vec_oe       acknowledge byte and its output enable
//   in_service, pending   one-hot in-service source, latched pending bits
module z80_irq_responder #(
    parameter int unsigned NSRC     = 4,
    parameter logic [7:0]  VEC_BASE = 8'h20,
    parameter logic [7:0]  RST_OPC  = 8'hFF,
    parameter int unsigned NMI_HOLD = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NSRC-1:0] irq_req,
    input  logic [NSRC-1:0] irq_mask,
    input  logic            nmi_req,
    input  logic            eoi,
    input  logic [1:0]      im_mode,
    input  logic            cpu_m1_n,
    input  logic            cpu_mreq_n,
    input  logic            cpu_iorq_n,
    input  logic            cpu_rd_n,
    input  logic [7:0]      cpu_do,
    output logic            cpu_int_n,
    output logic            cpu_nmi_n,
    output logic [7:0]      vec_out,
    output logic            vec_oe,
    output logic [NSRC-1:0] in_service,
    output logic [NSRC-1:0] pending
);

    localparam int unsigned WinW = (NSRC > 1) ? $clog2(NSRC) : 1;
    localparam int unsigned CntW = $clog2(NMI_HOLD + 1);

    typedef enum logic [1:0] {StIdle, StAck, StService, StSeenEd} state_e;

    state_e            state_q, state_d;
    logic [NSRC-1:0]   irq_prev_q;
    logic              nmi_prev_q;
    logic              m1_n_prev_q;
    logic [7:0]        opc_q;
    logic              fetch_seen_q;
    logic [NSRC-1:0]   pending_q, pending_d, pending_clr;
    logic [NSRC-1:0]   in_service_q, in_service_d;
    logic [WinW-1:0]   win_q, win_d, win_sel;
    logic [7:0]        vec_out_q, vec_out_d, vec_calc;
    logic              vec_oe_q, vec_oe_d;
    logic              int_n_q, int_n_d;
    logic              nmi_n_q, nmi_n_d;
    logic [CntW-1:0]   nmi_cnt_q, nmi_cnt_d;

    logic [NSRC-1:0]   irq_edge, unmasked;
    logic              nmi_edge, any_req, ack, fetch, m1_rise, opc_eval;

    assign irq_edge = irq_req & ~irq_prev_q;
    assign nmi_edge = nmi_req & ~nmi_prev_q;
    assign ack      = ~cpu_m1_n & ~cpu_iorq_n;
    assign fetch    = ~cpu_m1_n & ~cpu_mreq_n & ~cpu_rd_n & cpu_iorq_n;
    assign m1_rise  = cpu_m1_n & ~m1_n_prev_q;
    // Opcode captured during the fetch is judged once M1 ends.
    assign opc_eval = m1_rise & fetch_seen_q;

    assign unmasked = pending_q & ~irq_mask;
    assign any_req  = |unmasked;

    // Lowest unmasked index wins.
    always_comb begin
        win_sel = '0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (unmasked[i]) win_sel = WinW'(i);
        end
    end

    assign vec_calc = {VEC_BASE[7:1], 1'b0} + 8'({win_sel, 1'b0});

    always_comb begin
        state_d      = state_q;
        pending_clr  = '0;
        in_service_d = in_service_q;
        win_d        = win_q;
        vec_out_d    = vec_out_q;
        vec_oe_d     = vec_oe_q;
        int_n_d      = 1'b1;
        unique case (state_q)
            StIdle: begin
                int_n_d  = ~any_req;
                vec_oe_d = 1'b0;
                if (ack) begin
                    if (any_req) begin
                        state_d              = StAck;
                        win_d                = win_sel;
                        pending_clr[win_sel] = 1'b1;
                        vec_out_d            = im_mode[1] ? vec_calc : RST_OPC;
                        vec_oe_d             = 1'b1;
                        int_n_d              = 1'b1;
                    end else begin
                        vec_out_d = RST_OPC;
                    end
                end
            end
            StAck: begin
                if (!ack) begin
                    vec_oe_d     = 1'b0;
                    in_service_d = NSRC'(1) << win_q;
                    state_d      = StService;
                end
            end
            StService: begin
                if (eoi) begin
                    in_service_d = '0;
                    state_d      = StIdle;
                end else if (opc_eval && opc_q == 8'hED) begin
                    state_d = StSeenEd;
                end
            end
            StSeenEd: begin
                if (eoi) begin
                    in_service_d = '0;
                    state_d      = StIdle;
                end else if (opc_eval) begin
                    if (opc_q == 8'h4D) begin
                        in_service_d = '0;
                        state_d      = StIdle;
                    end else begin
                        state_d = StService;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // A new edge wins over the acknowledge clear on the same bit.
    assign pending_d = (pending_q & ~pending_clr) | irq_edge;

    always_comb begin
        nmi_cnt_d = nmi_cnt_q;
        if (nmi_cnt_q != '0) begin
            nmi_cnt_d = nmi_cnt_q - 1'b1;
        end else if (nmi_edge) begin
            nmi_cnt_d = CntW'(NMI_HOLD);
        end
        nmi_n_d = (nmi_cnt_d == '0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StIdle;
            irq_prev_q   <= '0;
            nmi_prev_q   <= 1'b0;
            m1_n_prev_q  <= 1'b1;
            opc_q        <= 8'h00;
            fetch_seen_q <= 1'b0;
            pending_q    <= '0;
            in_service_q <= '0;
            win_q        <= '0;
            vec_out_q    <= 8'h00;
            vec_oe_q     <= 1'b0;
            int_n_q      <= 1'b1;
            nmi_n_q      <= 1'b1;
            nmi_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            irq_prev_q   <= irq_req;
            nmi_prev_q   <= nmi_req;
            m1_n_prev_q  <= cpu_m1_n;
            if (fetch) opc_q <= cpu_do;
            if (fetch) begin
                fetch_seen_q <= 1'b1;
            end else if (m1_rise) begin
                fetch_seen_q <= 1'b0;
            end
            pending_q    <= pending_d;
            in_service_q <= in_service_d;
            win_q        <= win_d;
            vec_out_q    <= vec_out_d;
            vec_oe_q     <= vec_oe_d;
            int_n_q      <= int_n_d;
            nmi_n_q      <= nmi_n_d;
            nmi_cnt_q    <= nmi_cnt_d;
        end
    end

    assign cpu_int_n  = int_n_q;
    assign cpu_nmi_n  = nmi_n_q;
    assign vec_out    = vec_out_q;
    assign vec_oe     = vec_oe_q;
    assign in_service = in_service_q;
    assign pending    = pending_q;

endmodule

// File: tb/tb_z80_irq_responder.sv
// Self-checking bench for z80_irq_responder (default parameters).
module tb_z80_irq_responder;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] irq_req, irq_mask;
    logic       nmi_req, eoi;
    logic [1:0] im_mode;
    logic       cpu_m1_n, cpu_mreq_n, cpu_iorq_n, cpu_rd_n;
    logic [7:0] cpu_do;
    logic       cpu_int_n, cpu_nmi_n;
    logic [7:0] vec_out;
    logic       vec_oe;
    logic [3:0] in_service, pending;

    int n_vec = 0;
    int n_err = 0;
    logic [7:0] sb_q[$];

    z80_irq_responder dut (
        .clk        (clk),
        .reset      (reset),
        .irq_req    (irq_req),
        .irq_mask   (irq_mask),
        .nmi_req    (nmi_req),
        .eoi        (eoi),
        .im_mode    (im_mode),
        .cpu_m1_n   (cpu_m1_n),
        .cpu_mreq_n (cpu_mreq_n),
        .cpu_iorq_n (cpu_iorq_n),
        .cpu_rd_n   (cpu_rd_n),
        .cpu_do     (cpu_do),
        .cpu_int_n  (cpu_int_n),
        .cpu_nmi_n  (cpu_nmi_n),
        .vec_out    (vec_out),
        .vec_oe     (vec_oe),
        .in_service (in_service),
        .pending    (pending)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         src;
        logic [1:0] im;
        logic [7:0] vec;
        bit         use_eoi;
    } vec_t;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic bus_idle();
        cpu_m1_n   = 1'b1;
        cpu_mreq_n = 1'b1;
        cpu_iorq_n = 1'b1;
        cpu_rd_n   = 1'b1;
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        irq_req  = '0;
        irq_mask = '0;
        nmi_req  = 1'b0;
        eoi      = 1'b0;
        cpu_do   = 8'h00;
        bus_idle();
        tick();
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic raise_irq(input logic [3:0] bits);
        irq_req = bits;
        tick();
        irq_req = '0;
    endtask

    // Expected byte is queued when the acknowledge is driven and retired when vec_oe appears.
    task automatic do_ack(input logic [7:0] exp_vec);
        int waited;
        sb_q.push_back(exp_vec);
        cpu_m1_n   = 1'b0;
        cpu_iorq_n = 1'b0;
        waited     = 0;
        tick();
        while (!vec_oe && waited < 4) begin
            tick();
            waited++;
        end
        if (!vec_oe) begin
            chk("ack_vec_oe_timeout", {31'd0, vec_oe}, 32'd1);
            void'(sb_q.pop_front());
        end else begin
            chk("ack_vec", {24'd0, vec_out}, {24'd0, sb_q.pop_front()});
        end
        chk("ack_int_n_high", {31'd0, cpu_int_n}, 32'd1);
        tick();
        chk("ack_vec_oe_hold", {31'd0, vec_oe}, 32'd1);
        bus_idle();
        tick();
        chk("ack_vec_oe_drop", {31'd0, vec_oe}, 32'd0);
    endtask

    task automatic fetch(input logic [7:0] op);
        cpu_m1_n   = 1'b0;
        cpu_mreq_n = 1'b0;
        cpu_rd_n   = 1'b0;
        cpu_iorq_n = 1'b1;
        cpu_do     = op;
        tick();
        bus_idle();
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t       tbl[6];
        logic [3:0] bit_s;
        int         low_cnt;

        tbl[0] = '{src: 0, im: 2'd2, vec: 8'h20, use_eoi: 1'b0};
        tbl[1] = '{src: 1, im: 2'd3, vec: 8'h22, use_eoi: 1'b1};
        tbl[2] = '{src: 2, im: 2'd2, vec: 8'h24, use_eoi: 1'b0};
        tbl[3] = '{src: 3, im: 2'd2, vec: 8'h26, use_eoi: 1'b1};
        tbl[4] = '{src: 2, im: 2'd1, vec: 8'hFF, use_eoi: 1'b1};
        tbl[5] = '{src: 0, im: 2'd0, vec: 8'hFF, use_eoi: 1'b0};

        im_mode = 2'd2;
        do_reset();
        chk("rst_int_n", {31'd0, cpu_int_n}, 32'd1);
        chk("rst_nmi_n", {31'd0, cpu_nmi_n}, 32'd1);
        chk("rst_vec_out", {24'd0, vec_out}, 32'h00);
        chk("rst_vec_oe", {31'd0, vec_oe}, 32'd0);
        chk("rst_pending", {28'd0, pending}, 32'd0);
        chk("rst_in_service", {28'd0, in_service}, 32'd0);

        // Acknowledge with nothing pending: RST opcode, no enable, stays idle.
        cpu_m1_n   = 1'b0;
        cpu_iorq_n = 1'b0;
        tick();
        chk("empty_ack_vec_oe", {31'd0, vec_oe}, 32'd0);
        chk("empty_ack_vec", {24'd0, vec_out}, 32'hFF);
        bus_idle();
        tick();

        for (int i = 0; i < 6; i++) begin
            do_reset();
            im_mode = tbl[i].im;
            bit_s   = 4'(1 << tbl[i].src);
            raise_irq(bit_s);
            chk("tbl_pending", {28'd0, pending}, {28'd0, bit_s});
            chk("tbl_int_n_lag", {31'd0, cpu_int_n}, 32'd1);
            tick();
            chk("tbl_int_n_low", {31'd0, cpu_int_n}, 32'd0);
            do_ack(tbl[i].vec);
            chk("tbl_pending_clr", {28'd0, pending}, 32'd0);
            chk("tbl_in_service", {28'd0, in_service}, {28'd0, bit_s});
            if (tbl[i].use_eoi) begin
                eoi = 1'b1;
                tick();
                eoi = 1'b0;
            end else begin
                fetch(8'hED);
                fetch(8'h4D);
            end
            chk("tbl_in_service_clr", {28'd0, in_service}, 32'd0);
            tick();
            chk("tbl_int_n_idle", {31'd0, cpu_int_n}, 32'd1);
        end

        // Priority and no nesting until RETI.
        do_reset();
        im_mode = 2'd2;
        raise_irq(4'b1010);
        tick();
        chk("prio_int_n", {31'd0, cpu_int_n}, 32'd0);
        do_ack(8'h22);
        chk("prio_pending", {28'd0, pending}, 32'b1000);
        chk("prio_in_service", {28'd0, in_service}, 32'b0010);
        tick();
        chk("prio_no_nest", {31'd0, cpu_int_n}, 32'd1);
        fetch(8'hED);
        fetch(8'h00);
        chk("reti_ed00_keep", {28'd0, in_service}, 32'b0010);
        chk("reti_ed00_int_n", {31'd0, cpu_int_n}, 32'd1);
        fetch(8'hED);
        fetch(8'h4D);
        chk("reti_clear", {28'd0, in_service}, 32'd0);
        tick();
        chk("prio_int_n_again", {31'd0, cpu_int_n}, 32'd0);
        do_ack(8'h26);
        chk("prio_second_svc", {28'd0, in_service}, 32'b1000);

        // eoi while idle has no effect on a fresh request.
        do_reset();
        eoi = 1'b1;
        raise_irq(4'b0100);
        eoi = 1'b0;
        chk("eoi_idle_pending", {28'd0, pending}, 32'b0100);

        // Masking only gates signalling.
        do_reset();
        irq_mask = 4'b0001;
        raise_irq(4'b0001);
        chk("mask_pending", {28'd0, pending}, 32'b0001);
        tick();
        chk("mask_int_n_high", {31'd0, cpu_int_n}, 32'd1);
        irq_mask = 4'b0000;
        tick();
        chk("unmask_int_n_low", {31'd0, cpu_int_n}, 32'd0);

        // NMI pulse width, edge during pulse ignored, no effect on pending.
        do_reset();
        low_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            nmi_req = (i == 0 || i == 2);
            tick();
            if (!cpu_nmi_n) low_cnt++;
        end
        nmi_req = 1'b0;
        chk("nmi_width", low_cnt, 32'd4);
        chk("nmi_pending", {28'd0, pending}, 32'd0);

        // Simultaneous NMI and IRQ edges.
        do_reset();
        nmi_req = 1'b1;
        raise_irq(4'b0100);
        nmi_req = 1'b0;
        chk("simul_nmi_n", {31'd0, cpu_nmi_n}, 32'd0);
        chk("simul_pending", {28'd0, pending}, 32'b0100);
        tick();
        chk("simul_int_n", {31'd0, cpu_int_n}, 32'd0);

        // Reset in the middle of an acknowledge and an NMI pulse.
        do_reset();
        im_mode = 2'd2;
        nmi_req = 1'b1;
        raise_irq(4'b0011);
        nmi_req = 1'b0;
        tick();
        cpu_m1_n   = 1'b0;
        cpu_iorq_n = 1'b0;
        tick();
        chk("midack_vec_oe", {31'd0, vec_oe}, 32'd1);
        chk("midack_vec", {24'd0, vec_out}, 32'h20);
        reset = 1'b1;
        tick();
        chk("midack_rst_vec_oe", {31'd0, vec_oe}, 32'd0);
        chk("midack_rst_int_n", {31'd0, cpu_int_n}, 32'd1);
        chk("midack_rst_nmi_n", {31'd0, cpu_nmi_n}, 32'd1);
        chk("midack_rst_pending", {28'd0, pending}, 32'd0);
        chk("midack_rst_vec_out", {24'd0, vec_out}, 32'h00);
        reset = 1'b0;
        bus_idle();
        tick();
        tick();
        chk("post_rst_vec_oe", {31'd0, vec_oe}, 32'd0);
        chk("post_rst_nmi_n", {31'd0, cpu_nmi_n}, 32'd1);
        chk("post_rst_in_service", {28'd0, in_service}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
